// File: rtl/key_pkg.sv
// Shared constants and event layout for the key event scheduler.
// An event word is {pressed, key_idx}, with pressed in the MSB.
package key_pkg;
    localparam int KEYS_DEFAULT    = 61;
    localparam int IDX_W_DEFAULT   = 6;
    localparam int EVT_PRESSED_BIT = IDX_W_DEFAULT;
    localparam int EVT_W_DEFAULT   = IDX_W_DEFAULT + 1;

    typedef struct packed {
        logic                     pressed;
        logic [IDX_W_DEFAULT-1:0] idx;
    } key_evt_t;
endpackage

// File: rtl/key_event_fifo.sv
// Synchronous first-word-fall-through FIFO holding key events.
// A push into a full FIFO is ignored, even when a pop happens in the same cycle.
module key_event_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      level_d = level_q + 1'b1;
        else if (do_pop && !do_push) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i && !clr_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;
endmodule

// File: rtl/key_event_scheduler.sv
// Round-robin scanner turning debounced key level changes into queued
// {pressed, key_idx} events; stalls on a full FIFO rather than dropping changes.
module key_event_scheduler
    import key_pkg::*;
#(
    parameter int   KEYS        = KEYS_DEFAULT,
    parameter int   IDX_W       = IDX_W_DEFAULT,
    parameter int   FIFO_DEPTH  = 16,
    parameter logic PRESSED_LVL = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [KEYS-1:0]               keys_i,
    input  logic                          enable_i,
    input  logic                          flush_i,
    output logic                          evt_valid_o,
    input  logic                          evt_ready_i,
    output logic [IDX_W:0]                evt_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [IDX_W-1:0]              scan_idx_o
);
    logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
    logic [KEYS-1:0]  rep_q, rep_d;
    logic             cur, changed;
    logic             fifo_full, fifo_empty;
    logic             push, pop;
    logic [IDX_W:0]   evt_d;

    assign cur     = (keys_i[scan_idx_q] == PRESSED_LVL);
    assign changed = (cur != rep_q[scan_idx_q]);
    assign push    = enable_i && changed && !fifo_full && !flush_i;
    assign pop     = !fifo_empty && evt_ready_i && !flush_i;
    assign evt_d   = {cur, scan_idx_q};

    always_comb begin
        scan_idx_d = scan_idx_q;
        rep_d      = rep_q;
        // A pending change on a full FIFO parks the pointer until there is room.
        if (enable_i && (!changed || !fifo_full)) begin
            if (scan_idx_q == IDX_W'(KEYS-1)) scan_idx_d = '0;
            else                              scan_idx_d = scan_idx_q + 1'b1;
        end
        if (push) rep_d[scan_idx_q] = cur;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            scan_idx_q <= '0;
            rep_q      <= '0;
        end else begin
            scan_idx_q <= scan_idx_d;
            rep_q      <= rep_d;
        end
    end

    key_event_fifo #(
        .WIDTH (IDX_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (flush_i),
        .push_i  (push),
        .data_i  (evt_d),
        .pop_i   (pop),
        .data_o  (evt_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    assign evt_valid_o = !fifo_empty;
    assign scan_idx_o  = scan_idx_q;
endmodule

// File: doc/key_event_scheduler.md
Name: key_event_scheduler

Overview:
- Sits downstream of the per-key debouncer. It takes the debounced key vector and walks it with a round-robin scan pointer.
- Each key whose level differs from its last-reported state becomes an event: {pressed, key index}. Events are queued in order in a small FIFO and drained by the host-interface logic (SPI/USB report builder) through a valid/ready handshake.
- No state change is ever lost. Under back-pressure the scanner stalls instead of dropping events.

Parameters:
- KEYS, 61, number of debounced key inputs.
- IDX_W, 6, width of the key index; must satisfy 2^IDX_W >= KEYS.
- FIFO_DEPTH, 16, event FIFO entries; power of two, minimum 2.
- PRESSED_LVL, 1'b1, level of keys_i that means "pressed".

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- keys_i  in  KEYS  debounced key levels.
- enable_i  in  1  1 = scanner runs; 0 = scanner frozen, FIFO still drains.
- flush_i  in  1  one-cycle pulse: clear FIFO and reported state (host resync).
- evt_valid_o  out  1  event available.
- evt_ready_i  in  1  consumer accepts the event when valid & ready.
- evt_data_o  out  IDX_W+1  {pressed, key_idx}; pressed=1 means key went to PRESSED_LVL.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- scan_idx_o  out  IDX_W  current scan pointer (debug).

Behaviour:
- Reset (rst_i=1 at posedge): scan_idx=0, reported state rep[KEYS-1:0]=all "released", FIFO empty, evt_valid_o=0, evt_data_o=0, fifo_level_o=0.
  - Keys held through reset are therefore reported as presses on the first scan pass.
- Scan, every cycle with enable_i=1:
  - Compute cur = (keys_i[scan_idx] == PRESSED_LVL).
  - If cur != rep[scan_idx] and the FIFO is not full: push {cur, scan_idx}, set rep[scan_idx]=cur, advance scan_idx.
  - If cur != rep[scan_idx] and the FIFO is full: hold scan_idx, push nothing, leave rep unchanged. Retry each cycle.
  - If cur == rep[scan_idx]: advance scan_idx, no push.
- Wrap-around: scan_idx goes KEYS-1 -> 0. Indices >= KEYS are never visited.
- Full rule: push is blocked when level == FIFO_DEPTH, even if a pop occurs in the same cycle. This keeps the full check on registered state only.
- Simultaneous push and pop when not full: both occur, level unchanged.
- FIFO is first-word fall-through.
  - evt_valid_o = (level != 0).
  - evt_data_o = head entry, stable while valid & !ready.
- Latency: a push at posedge t gives evt_valid_o=1 after posedge t (when the FIFO was empty). Worst case from a keys_i change to the event appearing is KEYS+1 cycles, when the FIFO is not full.
- Ordering: events leave in push order. One key toggling twice before its index is revisited yields only the net change; the debounce period is far longer than KEYS cycles.
- enable_i=0: scan_idx and rep frozen, no pushes, pops continue.
- flush_i=1 at posedge (priority over push and pop in the same cycle):
  - FIFO emptied, rep=all released, scan_idx=0.
  - Any event offered in that cycle is discarded, even if evt_ready_i=1.
- rst_i has priority over flush_i. Reset mid-stream discards all queued events.

Decomposition:
- Shared package key_pkg: KEYS_DEFAULT=61, IDX_W_DEFAULT=6, and the event field layout (EVT_PRESSED_BIT=IDX_W, index in [IDX_W-1:0]).
- Sub-module key_event_fifo: synchronous FWFT FIFO with parameters WIDTH and DEPTH.
  - Ports: clk_i, rst_i, clr_i, push/pop, full/empty, level.
  - The scheduler instantiates one, driving clr_i from flush_i.

Test Plan:
- Reset with keys_i=0, evt_ready_i=1, run 200 cycles -> evt_valid_o never asserts, fifo_level_o=0.
- Set keys_i[5]=1 -> exactly one event {1,6'd5} within 62 cycles. Clear it -> {0,6'd5}. No duplicates over a further 200 cycles.
- Hold evt_ready_i=0, set keys 0..19 pressed -> level saturates at 16, scan_idx_o stalls at 16. Release ready -> 20 events in index order 0..19, none lost.
- Keys 3 and 40 pressed, with a single-cycle pop coinciding with a push while level=16 -> no push that cycle. Level goes 16->15, then 15->16 next cycle.
- 3 events queued, pulse flush_i with keys 7 and 9 held -> level 0 next cycle, then fresh events {1,7} and {1,9} re-reported.
- enable_i=0, toggle key 2 -> no event. enable_i=1 -> {1,2} within 62 cycles. rst_i mid-queue -> evt_valid_o=0 next cycle.
